// File: rtl/frame_tx_pkg.sv
// Shared definitions for the 1101-synchronised serial link (transmit and receive sides).
package frame_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        PARITY,
        GAP
    } tx_state_t;

    localparam logic [3:0] SYNC_WORD = 4'b1101;
    localparam int         SYNC_LEN  = 4;

    // Bit-counter width: must hold the longest phase length (sync, payload or gap).
    function automatic int cnt_width(input int data_w, input int idle_min);
        int m;
        m = SYNC_LEN;
        if (data_w > m)   m = data_w;
        if (idle_min > m) m = idle_min;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/frame_tx_1101_piso_shift.sv
// Parallel-load, MSB-first shift register; msb is the next bit to be serialised.
module piso_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb
);

    logic [DATA_W-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        sr <= '0;
        else if (load)  sr <= din;
        else if (shift) sr <= sr << 1;
    end

    assign msb = sr[DATA_W-1];

endmodule

// File: rtl/frame_tx_1101.sv
// Serial frame transmitter: sync word 1101, payload MSB first, even parity, forced idle gap.
module frame_tx_1101
    import frame_tx_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int IDLE_MIN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              data_out,
    output logic              busy,
    output logic              sof,
    output logic              done
);

    localparam int CNT_W = cnt_width(DATA_W, IDLE_MIN);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((IDLE_MIN > 0) ? IDLE_MIN - 1 : 0);

    tx_state_t        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             parity;
    logic             accept;
    logic             load, shift, sr_msb;
    logic             data_d, sof_d, done_d;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    piso_shift #(.DATA_W(DATA_W)) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (in_data),
        .msb   (sr_msb)
    );

    // Outputs are registered, so each branch computes the bit for the NEXT cycle.
    always_comb begin
        state_d = state;
        data_d  = 1'b0;
        sof_d   = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = SYNC;
                    load    = 1'b1;
                    sof_d   = 1'b1;
                    data_d  = SYNC_WORD[SYNC_LEN-1];
                end
            end
            SYNC: begin
                if (cnt == SYNC_LAST) begin
                    state_d = DATA;
                    data_d  = sr_msb;
                    shift   = 1'b1;
                end else begin
                    data_d = SYNC_WORD[2'(SYNC_LEN - 2) - cnt[1:0]];
                end
            end
            DATA: begin
                if (cnt == DATA_LAST) begin
                    state_d = PARITY;
                    data_d  = parity;
                    done_d  = 1'b1;
                end else begin
                    data_d = sr_msb;
                    shift  = 1'b1;
                end
            end
            PARITY: begin
                state_d = (IDLE_MIN > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (cnt == GAP_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d != state || state == IDLE) ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            parity   <= 1'b0;
            data_out <= 1'b0;
            sof      <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            data_out <= data_d;
            sof      <= sof_d;
            done     <= done_d;
            busy     <= (state_d != IDLE);
            if (accept) parity <= ^in_data;
        end
    end

endmodule

// File: tb/tb_frame_tx_1101.sv
// Scoreboarded bench: driver queues the expected line/sof/done per cycle, monitor compares.
module tb_frame_tx_1101;

    localparam int DW = 8;
    localparam int IM = 2;
    localparam int FLEN = DW + 6 + IM;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, data_out, busy, sof, done;

    always #5 clk = ~clk;

    frame_tx_1101 #(.DATA_W(DW), .IDLE_MIN(IM)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .data_out (data_out),
        .busy     (busy),
        .sof      (sof),
        .done     (done)
    );

    typedef struct packed {
        logic b;
        logic s;
        logic d;
    } exp_t;

    exp_t       q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         sof_cyc[$];
    int         det_hits = 0;
    logic [3:0] hist = 4'b0;

    function automatic void check1(input string name, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b want %b at cycle %0d", name, got, want, cyc);
        end
    endfunction

    function automatic void checkn(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d at cycle %0d", name, got, want, cyc);
        end
    endfunction

    // Reference frame: what the line must show, cycle by cycle, after an acceptance.
    function automatic void push_frame(input logic [DW-1:0] d);
        logic [3:0] sw;
        sw = 4'b1101;
        for (int i = 3; i >= 0; i--) q.push_back('{sw[i], 1'(i == 3), 1'b0});
        for (int i = DW - 1; i >= 0; i--) q.push_back('{d[i], 1'b0, 1'b0});
        q.push_back('{1'($countones(d) % 2), 1'b0, 1'b1});
        for (int i = 0; i < IM; i++) q.push_back('{1'b0, 1'b0, 1'b0});
    endfunction

    // Monitor + loopback 1101 detector on the serial line.
    always @(negedge clk) begin
        exp_t e;
        bit   eb;
        cyc++;
        hist = {hist[2:0], data_out};
        if (hist == 4'b1101) det_hits++;
        if (sof) sof_cyc.push_back(cyc);
        if (rst) begin
            check1("rst_data_out", data_out, 1'b0);
            check1("rst_busy", busy, 1'b0);
            check1("rst_sof", sof, 1'b0);
            check1("rst_done", done, 1'b0);
            check1("rst_in_ready", in_ready, 1'b1);
        end else begin
            eb = (q.size() > 0);
            check1("busy", busy, eb);
            check1("in_ready", in_ready, !eb);
            if (eb) begin
                e = q.pop_front();
                check1("data_out", data_out, e.b);
                check1("sof", sof, e.s);
                check1("done", done, e.d);
            end else begin
                check1("idle_data_out", data_out, 1'b0);
                check1("idle_sof", sof, 1'b0);
                check1("idle_done", done, 1'b0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic offer(input logic [DW-1:0] d, input bit keep);
        int n;
        n = 0;
        in_valid = 1'b1;
        while (!in_ready) begin
            in_data = DW'($urandom);
            @(negedge clk);
            n++;
            if (n > 200) begin
                check1("offer_timeout", 1'b0, 1'b1);
                in_valid = 1'b0;
                return;
            end
        end
        in_data = d;
        @(posedge clk);
        push_frame(d);
        @(negedge clk);
        in_valid = keep;
        in_data  = DW'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check1("idle_timeout", 1'b0, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int  h0;
        bit  keep, prev_keep;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);

        offer(8'hA5, 1'b0);
        wait_idle();
        offer(8'h07, 1'b0);
        wait_idle();

        // Back-to-back with in_valid held; in_data scribbled during frame 1.
        offer(8'hFF, 1'b1);
        offer(8'h00, 1'b0);
        wait_idle();
        if (sof_cyc.size() >= 2)
            checkn("sof_spacing", sof_cyc[sof_cyc.size()-1] - sof_cyc[sof_cyc.size()-2], FLEN);
        else
            checkn("sof_count", sof_cyc.size(), 2);

        // Reset during DATA bit 3 (payload bit 4 of 8'h3C is 1, so the line is high).
        offer(8'h3C, 1'b0);
        repeat (7) @(posedge clk);
        #2;
        check1("pre_rst_data_out", data_out, 1'b1);
        rst = 1'b1;
        q.delete();
        #1;
        check1("mid_rst_data_out", data_out, 1'b0);
        check1("mid_rst_busy", busy, 1'b0);
        check1("mid_rst_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        offer(8'h5A, 1'b0);
        wait_idle();

        // Loopback: three zero-payload frames must each trip the detector once.
        h0 = det_hits;
        offer(8'h00, 1'b1);
        offer(8'h00, 1'b1);
        offer(8'h00, 1'b0);
        wait_idle();
        checkn("loop_hits", det_hits - h0, 3);

        // Random traffic, random gaps, in_valid pulsed while busy.
        prev_keep = 1'b0;
        for (int i = 0; i < 40; i++) begin
            keep = (i < 39) ? 1'($urandom % 2) : 1'b0;
            if (!prev_keep) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid = (!in_ready) && ($urandom % 2 == 0);
                    in_data  = DW'($urandom);
                    @(negedge clk);
                end
            end
            offer(DW'($urandom), keep);
            prev_keep = keep;
        end
        in_valid = 1'b0;
        wait_idle();
        checkn("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
